// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Sits on the consumer side of the PLL lock interface. It brings the
//   asynchronous PLL LOCK signal into the PLL output clock domain and
//   sequences the system reset:
//     1. Reset stays asserted until the synchronised lock has been high for
//        STABLE_CYCLES consecutive cycles.
//     2. Reset then stays asserted for a further HOLD_CYCLES cycles.
//     3. Reset is released.
//   While running, the design re-asserts reset if lock stays low for
//   DROP_FILTER consecutive cycles. Each such filtered loss of lock is counted
//   in a saturating counter.
//
// Ports:
//   clk            in   1      PLL output clock (the only clock)
//   reset          in   1      synchronous, active-high reset
//   locked         in   1      PLL LOCK, asynchronous to clk
//   sys_reset      out  1      registered active-high system reset
//   ready          out  1      registered, always the inverse of sys_reset
//   state          out  2      0=WAIT_LOCK 1=STABLE 2=HOLD 3=RUN
//   lock_loss_cnt  out  CNT_W  saturating count of filtered lock losses
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int DROP_FILTER   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             locked,
    output logic             sys_reset,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    // One counter is shared by STABLE and HOLD, so it is sized for the larger
    // of the two terminal values. The drop filter has its own counter because
    // it is only used in RUN.
    localparam int SEQ_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam int DROP_W  = (DROP_FILTER > 1) ? $clog2(DROP_FILTER) : 1;

    localparam logic [SEQ_W-1:0]  STABLE_LAST = SEQ_W'(STABLE_CYCLES - 1);
    localparam logic [SEQ_W-1:0]  HOLD_LAST   = SEQ_W'(HOLD_CYCLES - 1);
    localparam logic [DROP_W-1:0] DROP_LAST   = DROP_W'(DROP_FILTER - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Lock synchroniser. Only the last flop (w_lock_s) is used anywhere.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync[0] <= 1'b0;
        end else begin
            r_sync[0] <= locked;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Sequencer FSM
    // -----------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;
    logic [SEQ_W-1:0]    r_cnt;
    logic [SEQ_W-1:0]    w_cnt_next;
    logic [DROP_W-1:0]   r_drop;
    logic [DROP_W-1:0]   w_drop_next;
    logic [CNT_W-1:0]    r_loss;
    logic [CNT_W-1:0]    w_loss_next;
    logic                r_sys_reset;
    logic                r_ready;
    logic                w_sys_reset_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_drop      <= '0;
            r_loss      <= '0;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_drop      <= w_drop_next;
            r_loss      <= w_loss_next;
            r_sys_reset <= w_sys_reset_next;
            r_ready     <= ~w_sys_reset_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_drop_next  = r_drop;
        w_loss_next  = r_loss;

        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_next = ST_STABLE;
                    w_cnt_next   = '0;
                end
            end

            ST_STABLE: begin
                // Any low sample restarts qualification. This is not a loss.
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            ST_HOLD: begin
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_next = ST_RUN;
                    w_drop_next  = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                if (w_lock_s) begin
                    w_drop_next = '0;
                end else if (r_drop == DROP_LAST) begin
                    w_state_next = ST_WAIT_LOCK;
                    w_drop_next  = '0;
                    if (!(&r_loss)) begin
                        w_loss_next = r_loss + 1'b1;
                    end
                end else begin
                    w_drop_next = r_drop + 1'b1;
                end
            end

            default: begin
                w_state_next = ST_WAIT_LOCK;
            end
        endcase

        // Outputs are a decode of the next state. As a result, the registered
        // reset and ready change only on the edge where the state changes.
        w_sys_reset_next = (w_state_next != ST_RUN);
    end

    assign sys_reset     = r_sys_reset;
    assign ready         = r_ready;
    assign state         = r_state;
    assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Purpose:
//   Directed testbench for pll_reset_sequencer with SYNC=2, STABLE=8, HOLD=4
//   and DROP=4. It drives two instances from the same stimulus: one with an
//   8-bit loss counter and one with a 2-bit loss counter that saturates.
//
// Structure:
//   - A vector table applies {reset, locked} for N cycles. It then checks
//     both instances against hand-computed expected values.
//   - Hand-written sequences measure the exact number of edges from lock
//     acquisition to release and from loss to re-assertion.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;

    logic       sys_reset_a, ready_a;
    logic [1:0] state_a;
    logic [7:0] loss_a;

    logic       sys_reset_b, ready_b;
    logic [1:0] state_b;
    logic [1:0] loss_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .SYNC_STAGES(2), .STABLE_CYCLES(8), .HOLD_CYCLES(4),
        .DROP_FILTER(4), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .locked(locked),
        .sys_reset(sys_reset_a), .ready(ready_a),
        .state(state_a), .lock_loss_cnt(loss_a)
    );

    pll_reset_sequencer #(
        .SYNC_STAGES(2), .STABLE_CYCLES(8), .HOLD_CYCLES(4),
        .DROP_FILTER(4), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .locked(locked),
        .sys_reset(sys_reset_b), .ready(ready_b),
        .state(state_b), .lock_loss_cnt(loss_b)
    );

    typedef struct {
        logic       rst;
        logic       lck;
        int         cycles;
        logic       exp_sr;
        logic       exp_rdy;
        logic [1:0] exp_st;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic lck, input int n,
                                input logic sr, input logic rdy,
                                input logic [1:0] st, input int c);
        vec_t v;
        v.rst = rst; v.lck = lck; v.cycles = n;
        v.exp_sr = sr; v.exp_rdy = rdy; v.exp_st = st; v.exp_cnt = c;
        vecs.push_back(v);
    endfunction

    function automatic int sat2(input int c);
        return (c > 3) ? 3 : c;
    endfunction

    // Advance one clock edge, then settle before inputs or outputs are touched.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic sr, input logic rdy,
                             input logic [1:0] st, input int c);
        check($sformatf("v%0d sys_reset", idx), int'(sys_reset_a), int'(sr));
        check($sformatf("v%0d ready", idx), int'(ready_a), int'(rdy));
        check($sformatf("v%0d state", idx), int'(state_a), int'(st));
        check($sformatf("v%0d loss_cnt8", idx), int'(loss_a), c);
        check($sformatf("v%0d loss_cnt2", idx), int'(loss_b), sat2(c));
        check($sformatf("v%0d sat_sys_reset", idx), int'(sys_reset_b), int'(sr));
        check($sformatf("v%0d sat_state", idx), int'(state_b), int'(st));
    endtask

    initial begin
        int e_found;

        // Reset and idle without lock.
        add(1, 0, 3,  1, 0, 0, 0);
        add(0, 0, 50, 1, 0, 0, 0);
        // Lock rises. After E13 the state is HOLD; at E14 the state is RUN.
        add(0, 1, 14, 1, 0, 2, 0);
        add(0, 1, 1,  0, 1, 3, 0);
        add(0, 1, 20, 0, 1, 3, 0);
        // A 3-cycle low glitch in RUN is filtered out.
        add(0, 0, 3,  0, 1, 3, 0);
        add(0, 1, 10, 0, 1, 3, 0);
        // A sustained drop: F0..F4 still RUN, F5 asserts reset.
        add(0, 0, 5,  0, 1, 3, 0);
        add(0, 0, 1,  1, 0, 0, 1);
        add(0, 0, 10, 1, 0, 0, 1);
        // A 1-cycle drop during STABLE at cnt=5 restarts qualification.
        add(0, 1, 6,  1, 0, 1, 1);
        add(0, 0, 1,  1, 0, 1, 1);
        add(0, 1, 1,  1, 0, 1, 1);
        add(0, 1, 1,  1, 0, 0, 1);
        add(0, 1, 12, 1, 0, 2, 1);
        add(0, 1, 1,  0, 1, 3, 1);
        // Losses 2..5: the 2-bit counter saturates at 3.
        for (int k = 2; k <= 5; k++) begin
            add(0, 0, 5,  0, 1, 3, k - 1);
            add(0, 0, 1,  1, 0, 0, k);
            add(0, 1, 14, 1, 0, 2, k);
            add(0, 1, 1,  0, 1, 3, k);
        end
        // A reset pulse in RUN, with lock held high, forces a full re-sequence.
        add(1, 1, 1,  1, 0, 0, 0);
        add(0, 1, 14, 1, 0, 2, 0);
        add(0, 1, 1,  0, 1, 3, 0);

        foreach (vecs[i]) begin
            reset  = vecs[i].rst;
            locked = vecs[i].lck;
            repeat (vecs[i].cycles) step();
            check_all(i, vecs[i].exp_sr, vecs[i].exp_rdy,
                      vecs[i].exp_st, vecs[i].exp_cnt);
            $display("vec %0d: reset=%0d locked=%0d cycles=%0d sys_reset=%0d state=%0d cnt=%0d/%0d",
                     i, vecs[i].rst, vecs[i].lck, vecs[i].cycles,
                     sys_reset_a, state_a, loss_a, loss_b);
        end

        // Hand-written sequence: exact edge count from lock rise to release.
        reset  = 1'b1;
        locked = 1'b0;
        repeat (2) step();
        reset  = 1'b0;
        step();
        locked = 1'b1;
        e_found = -1;
        for (int e = 0; e < 100; e++) begin
            step();
            if (!sys_reset_a) begin
                e_found = e;
                break;
            end
        end
        check("acquire_edge", e_found, 14);
        check("acquire_ready", int'(ready_a), 1);
        $display("seq acquire: sys_reset fell at edge E%0d", e_found);

        // Hand-written sequence: exact edge count from lock drop to re-assertion.
        repeat (5) step();
        locked = 1'b0;
        e_found = -1;
        for (int e = 0; e < 100; e++) begin
            step();
            if (sys_reset_a) begin
                e_found = e;
                break;
            end
        end
        check("loss_edge", e_found, 5);
        check("loss_cnt", int'(loss_a), 1);
        check("loss_state", int'(state_a), 0);
        $display("seq loss: sys_reset rose at edge F%0d", e_found);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
